// File: rtl/lbm_pkg.sv
// rtl/lbm_pkg.sv - shared D2Q9 lattice constants, FSM state type and velocity tables
package lbm_pkg;

    localparam int Q = 9;
    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Lattice velocity components per direction; 2'b11 encodes -1
    localparam logic signed [1:0] CX [Q] = '{
        2'sb00, 2'sb01, 2'sb00, 2'sb11, 2'sb00, 2'sb01, 2'sb11, 2'sb11, 2'sb01
    };
    localparam logic signed [1:0] CY [Q] = '{
        2'sb00, 2'sb00, 2'sb01, 2'sb00, 2'sb11, 2'sb01, 2'sb01, 2'sb11, 2'sb11
    };

endpackage

// File: rtl/d2q9_accum.sv
// rtl/d2q9_accum.sv - per-node rho/mx/my accumulators weighted by the D2Q9 velocity table
module d2q9_accum
    import lbm_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         clear,
    input  logic                         en,
    input  logic [3:0]                   dir,
    input  logic signed [DATA_WIDTH-1:0] f_data,
    output logic signed [DATA_WIDTH-1:0] rho,
    output logic signed [DATA_WIDTH-1:0] mx,
    output logic signed [DATA_WIDTH-1:0] my
);

    logic signed [1:0] cx;
    logic signed [1:0] cy;

    always_comb begin
        cx = '0;
        cy = '0;
        if (dir < 4'(Q)) begin
            cx = CX[dir];
            cy = CY[dir];
        end
    end

    // Velocity components are only -1/0/+1, so add/subtract replaces a multiply
    function automatic logic signed [DATA_WIDTH-1:0] weigh(
        input logic signed [DATA_WIDTH-1:0] acc,
        input logic signed [1:0]            c,
        input logic signed [DATA_WIDTH-1:0] v
    );
        case (c)
            2'sb01:  weigh = acc + v;
            2'sb11:  weigh = acc - v;
            default: weigh = acc;
        endcase
    endfunction

    always_ff @(posedge Clk) begin
        if (Reset || clear) begin
            rho <= '0;
            mx  <= '0;
            my  <= '0;
        end else if (en) begin
            rho <= rho + f_data;
            mx  <= weigh(mx, cx, f_data);
            my  <= weigh(my, cy, f_data);
        end
    end

endmodule

// File: rtl/moment_calc.sv
// rtl/moment_calc.sv - full-grid sweep computing D2Q9 density and momenta into the moment RAMs
module moment_calc
    import lbm_pkg::*;
#(
    parameter int DEPTH         = 16*16,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH),
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         start,
    output logic [ADDRESS_WIDTH+3:0]     f_addr,
    input  logic signed [DATA_WIDTH-1:0] f_data,
    output logic [ADDRESS_WIDTH-1:0]     m_addr,
    output logic                         m_we,
    output logic signed [DATA_WIDTH-1:0] rho_out,
    output logic signed [DATA_WIDTH-1:0] mx_out,
    output logic signed [DATA_WIDTH-1:0] my_out,
    output logic                         busy,
    output logic                         done
);

    state_t                   state;
    state_t                   state_nxt;
    logic [ADDRESS_WIDTH-1:0] node;
    logic [3:0]               dir;
    logic                     last_node;
    logic                     last_dir;
    logic                     acc_clear;
    logic                     acc_en;

    assign last_node = (node == ADDRESS_WIDTH'(DEPTH - 1));
    assign last_dir  = (dir == 4'(Q - 1));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            node <= '0;
            dir  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        node <= '0;
                        dir  <= '0;
                    end
                end
                ACCUM: begin
                    if (!last_dir) begin
                        dir <= dir + 4'd1;
                    end
                end
                WRITE: begin
                    if (!last_node) begin
                        node <= node + ADDRESS_WIDTH'(1);
                        dir  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACCUM;
            ACCUM:   if (last_dir) state_nxt = WRITE;
            WRITE:   state_nxt = last_node ? DONE : ACCUM;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == ACCUM) || (state == WRITE);
        done      = (state == DONE);
        m_we      = (state == WRITE);
        m_addr    = (state == WRITE) ? node : '0;
        f_addr    = (state == ACCUM) ? {node, dir} : '0;
        acc_en    = (state == ACCUM);
        // Accumulators keep the last node's sums through DONE and IDLE
        acc_clear = ((state == IDLE) && start) || ((state == WRITE) && !last_node);
    end

    d2q9_accum #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_accum (
        .Clk    (Clk),
        .Reset  (Reset),
        .clear  (acc_clear),
        .en     (acc_en),
        .dir    (dir),
        .f_data (f_data),
        .rho    (rho_out),
        .mx     (mx_out),
        .my     (my_out)
    );

endmodule

// File: tb/tb_moment_calc.sv
// tb/tb_moment_calc.sv - directed self-checking bench for moment_calc on a 4-node grid
module tb_moment_calc;

    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);
    localparam int DW    = 32;

    logic                 Clk;
    logic                 Reset;
    logic                 start;
    logic [AW+3:0]        f_addr;
    logic signed [DW-1:0] f_data;
    logic [AW-1:0]        m_addr;
    logic                 m_we;
    logic signed [DW-1:0] rho_out;
    logic signed [DW-1:0] mx_out;
    logic signed [DW-1:0] my_out;
    logic                 busy;
    logic                 done;

    int mode;
    int n_assert;
    int n_fail;

    moment_calc #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DW)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .start   (start),
        .f_addr  (f_addr),
        .f_data  (f_data),
        .m_addr  (m_addr),
        .m_we    (m_we),
        .rho_out (rho_out),
        .mx_out  (mx_out),
        .my_out  (my_out),
        .busy    (busy),
        .done    (done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always_comb begin
        f_data = '0;
        case (mode)
            0: f_data = 32'sd1;
            1: f_data = (f_addr[3:0] == 4'd1) ? 32'sd5 : 32'sd0;
            2: f_data = (f_addr[3:0] == 4'd7) ? 32'sd7 : 32'sd0;
            3: f_data = 32'(f_addr) + 32'sd1;
            4: f_data = (f_addr[3:0] <= 4'd1) ? 32'sh7FFFFFFF : 32'sd0;
            default: f_data = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Hand-derived moments per pattern; pattern 3 gives rho=144k+45, mx=-2, my=-6 at node k
    task automatic exp_moments(input int md, input int k,
                               output logic [31:0] r, output logic [31:0] x, output logic [31:0] y);
        case (md)
            0: begin r = 32'd9;          x = 32'd0;          y = 32'd0;  end
            1: begin r = 32'd5;          x = 32'd5;          y = 32'd0;  end
            2: begin r = 32'd7;          x = -32'sd7;        y = -32'sd7; end
            3: begin r = 32'(144*k + 45); x = -32'sd2;       y = -32'sd6; end
            default: begin r = 32'hFFFFFFFE; x = 32'h7FFFFFFF; y = 32'd0; end
        endcase
    endtask

    task automatic check_cycle(input int c, input int md);
        logic [31:0] r, x, y;
        bit wr;
        wr = (c % 10 == 0) && (c <= 40);
        chk($sformatf("busy_c%0d", c), 32'(busy), 32'(c <= 40));
        chk($sformatf("done_c%0d", c), 32'(done), 32'(c == 41));
        chk($sformatf("m_we_c%0d", c), 32'(m_we), 32'(wr));
        if (wr) begin
            exp_moments(md, c/10 - 1, r, x, y);
            chk($sformatf("m_addr_c%0d", c), 32'(m_addr), 32'(c/10 - 1));
            chk($sformatf("rho_c%0d", c), rho_out, r);
            chk($sformatf("mx_c%0d", c), mx_out, x);
            chk($sformatf("my_c%0d", c), my_out, y);
        end else if (c <= 40) begin
            chk($sformatf("f_addr_c%0d", c), 32'(f_addr), 32'(((c-1)/10)*16 + (c-1)%10));
        end else begin
            chk($sformatf("f_addr_c%0d", c), 32'(f_addr), 32'd0);
        end
    endtask

    task automatic sweep(input int md, input bit pulse15);
        mode  = md;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 41; c++) begin
            check_cycle(c, md);
            start = (pulse15 && c == 15);
            if (c < 41) step();
        end
        step();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_m_we", 32'(m_we), 32'd0);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        mode     = 0;
        Reset    = 1'b1;
        start    = 1'b0;
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_m_we", 32'(m_we), 32'd0);
        chk("rst_f_addr", 32'(f_addr), 32'd0);
        chk("rst_m_addr", 32'(m_addr), 32'd0);
        chk("rst_rho", rho_out, 32'd0);
        chk("rst_mx", mx_out, 32'd0);
        chk("rst_my", my_out, 32'd0);
        Reset = 1'b0;
        step();

        sweep(0, 1'b0);
        sweep(1, 1'b0);
        sweep(2, 1'b0);
        sweep(3, 1'b1);
        sweep(4, 1'b0);
        chk("hold_rho_idle", rho_out, 32'hFFFFFFFE);

        // Start held high: the next sweep starts from IDLE right after DONE
        mode  = 0;
        start = 1'b1;
        step();
        for (int c = 1; c <= 52; c++) begin
            if (c <= 41) begin
                check_cycle(c, 0);
            end else if (c == 42) begin
                chk("hold_busy_c42", 32'(busy), 32'd0);
                chk("hold_m_we_c42", 32'(m_we), 32'd0);
            end else if (c < 52) begin
                chk($sformatf("hold_busy_c%0d", c), 32'(busy), 32'd1);
                chk($sformatf("hold_m_we_c%0d", c), 32'(m_we), 32'd0);
            end else begin
                chk("hold_m_we_c52", 32'(m_we), 32'd1);
                chk("hold_m_addr_c52", 32'(m_addr), 32'd0);
                chk("hold_rho_c52", rho_out, 32'd9);
            end
            if (c == 43) start = 1'b0;
            if (c < 52) step();
        end
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        step();

        // Reset mid-sweep while node 2 is accumulating
        mode  = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 25; c++) step();
        chk("mid_f_addr_c25", 32'(f_addr), 32'd36);
        chk("mid_busy_c25", 32'(busy), 32'd1);
        Reset = 1'b1;
        step();
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_m_we", 32'(m_we), 32'd0);
        chk("mid_rst_f_addr", 32'(f_addr), 32'd0);
        chk("mid_rst_rho", rho_out, 32'd0);
        Reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            chk($sformatf("mid_idle_m_we_%0d", c), 32'(m_we), 32'd0);
            chk($sformatf("mid_idle_busy_%0d", c), 32'(busy), 32'd0);
        end
        sweep(3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
